// File: rtl/lfsr_bank_if.sv
// lfsr_bank_if: seed-load and output-stream handshake bundle for lfsr_bank.
// master = producer of seeds / consumer of LFSR words; slave = lfsr_bank.
interface lfsr_bank_if #(
    parameter int WIDTH = 32,
    parameter int CW    = 2
);
    logic             seed_valid;
    logic             seed_ready;
    logic [CW-1:0]    seed_ch;
    logic [WIDTH-1:0] seed_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_ch;
    logic [WIDTH-1:0] out_data;

    modport master (
        output seed_valid, seed_ch, seed_data, out_ready,
        input  seed_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  seed_valid, seed_ch, seed_data, out_ready,
        output seed_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/lfsr_bank.sv
// lfsr_bank: CHANNELS independent Fibonacci-style LFSRs, seedable, read round-robin.
// Optional macro LFSR_BANK_ZERO_GUARD_EN replaces zero seeds with the channel reset value.
module lfsr_bank #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 4,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h0000_0001)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_all,
    lfsr_bank_if.slave bus,
    output logic       zero_fix
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {ST_RESET, ST_RUN} state_t;

    state_t           r_st;
    state_t           w_st_nxt;
    logic [WIDTH-1:0] r_state [CHANNELS];
    logic [WIDTH-1:0] w_nxt   [CHANNELS];
    logic [CW-1:0]    r_out_ch;
    logic [CW-1:0]    w_out_ch_nxt;
    logic             r_zero_fix;
    logic             w_zf_nxt;
    logic             w_live;
    logic             w_hs;
    logic             w_seed_hit;
    logic [WIDTH-1:0] w_out_data;
`ifdef LFSR_BANK_ZERO_GUARD_EN
    logic             w_zero_seed;
`endif

    function automatic logic [WIDTH-1:0] rst_val(input int unsigned c);
        logic [2*WIDTH-1:0] w_dbl;
        w_dbl = {DEFAULT_SEED, DEFAULT_SEED} << c;
        return w_dbl[2*WIDTH-1 -: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
        return {^(s & TAPS), s[WIDTH-1:1]};
    endfunction

    always_comb begin
        w_st_nxt     = ST_RUN;
        w_live       = (r_st == ST_RUN);
        w_hs         = w_live & bus.out_ready;
        // Channel indices at or beyond CHANNELS are accepted but never match a channel.
        w_seed_hit   = w_live & bus.seed_valid &
                       ({1'b0, bus.seed_ch} < (CW+1)'(CHANNELS));
        w_out_ch_nxt = r_out_ch;
        w_out_data   = '0;
`ifdef LFSR_BANK_ZERO_GUARD_EN
        w_zero_seed  = (bus.seed_data == '0);
        w_zf_nxt     = w_seed_hit & w_zero_seed;
`else
        w_zf_nxt     = 1'b0;
`endif
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            w_nxt[c] = r_state[c];
            if (run_all || (w_hs && r_out_ch == CW'(c)))
                w_nxt[c] = step(r_state[c]);
            // A seed load overrides a same-cycle step on that channel.
            if (w_seed_hit && bus.seed_ch == CW'(c)) begin
`ifdef LFSR_BANK_ZERO_GUARD_EN
                w_nxt[c] = w_zero_seed ? rst_val(c) : bus.seed_data;
`else
                w_nxt[c] = bus.seed_data;
`endif
            end
            if (r_out_ch == CW'(c))
                w_out_data = r_state[c];
        end
        if (w_hs)
            w_out_ch_nxt = (r_out_ch == CW'(CHANNELS - 1)) ? '0 : r_out_ch + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_st       <= ST_RESET;
            r_out_ch   <= '0;
            r_zero_fix <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++)
                r_state[c] <= rst_val(c);
        end else begin
            r_st       <= w_st_nxt;
            r_out_ch   <= w_out_ch_nxt;
            r_zero_fix <= w_zf_nxt;
            for (int unsigned c = 0; c < CHANNELS; c++)
                r_state[c] <= w_nxt[c];
        end
    end

    assign bus.seed_ready = w_live;
    assign bus.out_valid  = w_live;
    assign bus.out_ch     = r_out_ch;
    assign bus.out_data   = w_out_data;
    assign zero_fix       = r_zero_fix;
endmodule

// File: tb/tb_lfsr_bank.sv
// tb_lfsr_bank: directed vector table for the default 4-channel bank plus a
// short 3-channel sequence for out-of-range seed channels and non-power-of-2 wrap.
module tb_lfsr_bank;
    logic clk = 1'b0;
    logic rst, rst3, run_all, run_all3;
    logic zf, zf3;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    lfsr_bank_if #(.WIDTH(32), .CW(2)) b  ();
    lfsr_bank_if #(.WIDTH(32), .CW(2)) b3 ();

    lfsr_bank #(.WIDTH(32), .CHANNELS(4)) u_dut (
        .clk(clk), .rst(rst), .run_all(run_all), .bus(b.slave), .zero_fix(zf)
    );

    lfsr_bank #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .clk(clk), .rst(rst3), .run_all(run_all3), .bus(b3.slave), .zero_fix(zf3)
    );

`ifdef LFSR_BANK_ZERO_GUARD_EN
    localparam logic        ZF_EXP = 1'b1;
    localparam logic [31:0] C2_A   = 32'h0000_0004;
    localparam logic [31:0] C2_B   = 32'h0000_0002;
`else
    localparam logic        ZF_EXP = 1'b0;
    localparam logic [31:0] C2_A   = 32'h0000_0000;
    localparam logic [31:0] C2_B   = 32'h0000_0000;
`endif

    typedef struct {
        logic        rst;
        logic        run_all;
        logic        sv;
        logic [1:0]  sch;
        logic [31:0] sdata;
        logic        rdy;
        logic        ev;
        logic [1:0]  ech;
        logic [31:0] edata;
        logic        ezf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic ra, input logic sv, input logic [1:0] sch,
                       input logic [31:0] sd, input logic rdy, input logic ev,
                       input logic [1:0] ech, input logic [31:0] ed, input logic ezf);
        vq.push_back('{r, ra, sv, sch, sd, rdy, ev, ech, ed, ezf});
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, release, round-robin stepping from reset seeds 1/2/4/8
        add(0,0,0,0,32'h0,0, 0,0,32'h0000_0001,0);
        add(0,0,0,0,32'h0,1, 0,0,32'h0000_0001,0);
        add(1,0,0,0,32'h0,1, 1,0,32'h0000_0001,0);
        add(1,0,0,0,32'h0,1, 1,1,32'h0000_0002,0);
        add(1,0,0,0,32'h0,1, 1,2,32'h0000_0004,0);
        add(1,0,0,0,32'h0,1, 1,3,32'h0000_0008,0);
        add(1,0,0,0,32'h0,1, 1,0,32'h8000_0000,0);
        add(1,0,0,0,32'h0,1, 1,1,32'h8000_0001,0);
        add(1,0,0,0,32'h0,1, 1,2,32'h0000_0002,0);
        add(1,0,0,0,32'h0,1, 1,3,32'h0000_0004,0);
        add(1,0,0,0,32'h0,1, 1,0,32'hC000_0000,0);
        for (int i = 0; i < 10; i++)
            add(1,0,0,0,32'h0,0, 1,0,32'hC000_0000,0);
        // seed collides with handshake on ch0
        add(1,0,1,0,32'h1234_5678,1, 1,1,32'h4000_0000,0);
        add(1,0,0,0,32'h0,1, 1,2,32'h8000_0001,0);
        add(1,0,0,0,32'h0,1, 1,3,32'h0000_0002,0);
        add(1,0,0,0,32'h0,1, 1,0,32'h1234_5678,0);
        // zero seed to ch2 while holding
        add(1,0,1,2,32'h0,0, 1,0,32'h1234_5678,ZF_EXP);
        add(1,0,0,0,32'h0,1, 1,1,32'h2000_0000,0);
        add(1,0,0,0,32'h0,1, 1,2,C2_A,0);
        add(1,0,0,0,32'h0,1, 1,3,32'h8000_0001,0);
        add(1,0,0,0,32'h0,1, 1,0,32'h891A_2B3C,0);
        add(1,0,0,0,32'h0,1, 1,1,32'h1000_0000,0);
        add(1,0,0,0,32'h0,1, 1,2,C2_B,0);
        // free run from reset, handshake adds no step, reset mid-run wins
        add(0,1,0,0,32'h0,0, 0,0,32'h0000_0001,0);
        add(1,1,0,0,32'h0,0, 1,0,32'h8000_0000,0);
        add(1,1,0,0,32'h0,0, 1,0,32'hC000_0000,0);
        add(1,1,0,0,32'h0,0, 1,0,32'hE000_0000,0);
        add(1,1,0,0,32'h0,1, 1,1,32'h1000_0000,0);
        add(0,1,1,1,32'hAAAA_5555,1, 0,0,32'h0000_0001,0);
        add(1,0,0,0,32'h0,0, 1,0,32'h0000_0001,0);
        add(1,0,0,0,32'h0,1, 1,1,32'h0000_0002,0);

        rst3 = 1'b0; run_all3 = 1'b0;
        b3.seed_valid = 1'b0; b3.seed_ch = '0; b3.seed_data = '0; b3.out_ready = 1'b0;

        foreach (vq[i]) begin
            rst          = vq[i].rst;
            run_all      = vq[i].run_all;
            b.seed_valid = vq[i].sv;
            b.seed_ch    = vq[i].sch;
            b.seed_data  = vq[i].sdata;
            b.out_ready  = vq[i].rdy;
            tick();
            n_vec++;
            chk("out_valid",  i, 32'(b.out_valid),  32'(vq[i].ev));
            chk("seed_ready", i, 32'(b.seed_ready), 32'(vq[i].ev));
            chk("out_ch",     i, 32'(b.out_ch),     32'(vq[i].ech));
            chk("out_data",   i, b.out_data,        vq[i].edata);
            chk("zero_fix",   i, 32'(zf),           32'(vq[i].ezf));
        end

        // 3-channel bank: seed to ch3 is discarded, out_ch wraps 2 -> 0
        rst3 = 1'b1;
        tick();
        n_vec++;
        chk("c3_release_data", 100, b3.out_data, 32'h0000_0001);
        b3.seed_valid = 1'b1; b3.seed_ch = 2'd3; b3.seed_data = 32'hDEAD_BEEF;
        tick();
        n_vec++;
        chk("c3_oob_ch",   101, 32'(b3.out_ch), 32'd0);
        chk("c3_oob_data", 101, b3.out_data,    32'h0000_0001);
        chk("c3_oob_zf",   101, 32'(zf3),       32'd0);
        b3.seed_valid = 1'b0; b3.out_ready = 1'b1;
        tick();
        n_vec++;
        chk("c3_ch1", 102, 32'(b3.out_ch), 32'd1);
        chk("c3_d1",  102, b3.out_data,    32'h0000_0002);
        tick();
        n_vec++;
        chk("c3_ch2", 103, 32'(b3.out_ch), 32'd2);
        chk("c3_d2",  103, b3.out_data,    32'h0000_0004);
        tick();
        n_vec++;
        chk("c3_wrap_ch", 104, 32'(b3.out_ch), 32'd0);
        chk("c3_wrap_d",  104, b3.out_data,    32'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lfsr_bank.md
LFSR_BANK -- requirements
Module: lfsr_bank

Interface
REQ-001 Parameter WIDTH, default 32: LFSR register width in bits, legal range 8..64.
REQ-002 Parameter CHANNELS, default 4: number of independent LFSR channels, legal range 1..16; CW = max(1, clog2(CHANNELS)).
REQ-003 Parameter TAPS, default 32'h8020_0003: feedback tap mask, WIDTH bits; bit 0 must be 1.
REQ-004 Parameter DEFAULT_SEED, default 32'h0000_0001: nonzero base seed, WIDTH bits.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-low reset.
REQ-007 Port run_all, input, 1: free-run mode select.
REQ-008 Port seed_valid, input, 1: seed load request.
REQ-009 Port seed_ready, output, 1: seed load accept.
REQ-010 Port seed_ch, input, CW: target channel of the seed load.
REQ-011 Port seed_data, input, WIDTH: seed value.
REQ-012 Port out_valid, output, 1: out_data is valid.
REQ-013 Port out_ready, input, 1: consumer accepts out_data.
REQ-014 Port out_ch, output, CW: channel currently presented.
REQ-015 Port out_data, output, WIDTH: current state of channel out_ch.
REQ-016 Port zero_fix, output, 1: one-cycle pulse flagging that a zero seed was replaced.

Function
REQ-017 Step rule: fb = XOR over i of (state[i] AND TAPS[i]); next = {fb, state[WIDTH-1:1]}.
REQ-018 Reset value of channel c SHALL be DEFAULT_SEED rotated left by c bits.
REQ-019 seed_ready and out_valid SHALL be 1 in every cycle after reset is released.
REQ-020 A seed is accepted when seed_valid and seed_ready are both 1; seed_data is written to channel seed_ch at that edge.
REQ-021 A seed_ch value >= CHANNELS SHALL be accepted and discarded with no state change.
REQ-022 Output handshake fires when out_valid and out_ready are both 1.
REQ-023 When run_all=0, a handshake steps channel out_ch once; all other channels hold.
REQ-024 When run_all=1, every channel steps every cycle regardless of the handshake; the handshake does not add an extra step.
REQ-025 On a handshake, out_ch SHALL advance to (out_ch+1) mod CHANNELS; CHANNELS=1 keeps out_ch at 0.
REQ-026 Seed load and step on the same channel in the same cycle: the seed wins and that step is dropped; out_ch still advances.
REQ-027 out_data is a combinational mux of the registered channel states; latency from a load or step to its visibility on out_data is one cycle.
REQ-028 out_data and out_ch SHALL be stable while out_valid=1 and out_ready=0, except when run_all=1 or a seed load targets out_ch.

Reset
REQ-029 While rst=0 at an edge: all channels load their reset values, out_ch=0, out_valid=0, seed_ready=0, zero_fix=0.
REQ-030 Reset asserted mid-operation SHALL override any handshake, seed load or step in the same cycle.

Configuration
REQ-031 Macro LFSR_BANK_ZERO_GUARD_EN defined: an accepted seed_data of 0 loads that channel's reset value instead, and zero_fix pulses 1 in the following cycle.
REQ-032 Macro LFSR_BANK_ZERO_GUARD_EN undefined: a zero seed is loaded verbatim and the channel stays at 0 (locked); zero_fix is tied to 0.

Verification
REQ-033 Reset release, run_all=0, out_ready=1 -> first out_data 0x0000_0001 on ch0, then 0x0000_0002 on ch1; ch0 state becomes 0x8000_0000.
REQ-034 Ch1 state 0x0000_0002 stepped -> 0x8000_0001; ch0 state 0x8000_0000 stepped -> 0xC000_0000.
REQ-035 out_ready=0 for 10 cycles with run_all=0 -> out_ch and out_data unchanged throughout.
REQ-036 Seed ch0 = 0x1234_5678 in the same cycle as a ch0 handshake -> ch0 holds 0x1234_5678 with no step; out_ch=1.
REQ-037 Seed value 0 to ch2 -> with LFSR_BANK_ZERO_GUARD_EN: ch2 = 0x0000_0004 and zero_fix pulses for one cycle; without the macro: ch2 = 0 and stays 0 after stepping.
REQ-038 run_all=1 for 3 cycles from reset, out_ready=0 -> ch0 = 0xE000_0000; rst=0 mid-run -> all channels return to their reset values.
